jtcontra_layer_mix: RTL and testbench

// - Parametrised N-layer colour mixer for the Konami 007121-based video tops; successor to the fixed 2-layer colmix.
// - Takes one pixel per tile/object layer, applies per-layer enable and a run-time priority order, looks up a
//   CPU-writable xBGR555 palette and drives blanked RGB with matching delayed blanking.
// - Sits after the jtcontra_gfx instances; the CPU reaches the palette through pal_cs.

---
 rtl/jtcontra_layer_mix.sv | 76 +++++++
 tb/tb_jtcontra_layer_mix.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jtcontra_layer_mix.sv
// jtcontra_layer_mix: N-layer priority mixer with CPU-writable xBGR555 palette and aligned blanking
module jtcontra_layer_mix #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 7,
  parameter int LSELW  = 1,
  localparam int PALW  = LSELW + PXLW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   cpu_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  input  logic [LAYERS*PXLW-1:0] pxl_in,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic                   prio_rev,
  input  logic                   pal_cs,
  input  logic                   cpu_rnw,
  input  logic [PALW:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  output logic [4:0]             red,
  output logic [4:0]             green,
  output logic [4:0]             blue
);
  logic [7:0]       pal_hi [0:2**PALW-1];
  logic [7:0]       pal_lo [0:2**PALW-1];
  logic [LSELW-1:0] sel;
  logic [PALW-1:0]  nxt_idx, pal_idx;
  logic [14:0]      pal_q;
  logic             cen_d, lhbl1, lvbl1;
  always_comb begin
    sel = prio_rev ? '0 : LSELW'(LAYERS-1);
    for (int k = LAYERS-1; k >= 0; k--)
      if (!prio_rev && gfx_en[k] && pxl_in[k*PXLW +: 4] != 4'd0) sel = LSELW'(k);
    for (int k = 0; k < LAYERS; k++)
      if (prio_rev && gfx_en[k] && pxl_in[k*PXLW +: 4] != 4'd0) sel = LSELW'(k);
    nxt_idx = {sel, pxl_in[sel*PXLW +: PXLW]};
  end
  always_ff @(posedge clk)
    if (pal_cs && !cpu_rnw && cpu_cen) begin
      if (cpu_addr[0]) pal_lo[cpu_addr[PALW:1]] <= cpu_dout;
      else             pal_hi[cpu_addr[PALW:1]] <= cpu_dout;
    end
  // Video reads the palette only once per pixel, so a colliding CPU write shows from the next pixel on
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cen_d    <= 1'b0;
      pal_q    <= '0;
      pal_idx  <= '0;
      pal_dout <= '0;
      lhbl1    <= 1'b0;
      lvbl1    <= 1'b0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else begin
      cen_d <= pxl_cen;
      if (cen_d) pal_q <= {pal_hi[pal_idx][6:0], pal_lo[pal_idx]};
      if (pal_cs) pal_dout <= cpu_addr[0] ? pal_lo[cpu_addr[PALW:1]] : pal_hi[cpu_addr[PALW:1]];
      if (pxl_cen) begin
        pal_idx  <= nxt_idx;
        lhbl1    <= LHBL;
        lvbl1    <= LVBL;
        LHBL_dly <= lhbl1;
        LVBL_dly <= lvbl1;
        red      <= lhbl1 && lvbl1 ? pal_q[4:0] : 5'd0;
        green    <= lhbl1 && lvbl1 ? pal_q[9:5] : 5'd0;
        blue     <= lhbl1 && lvbl1 ? pal_q[14:10] : 5'd0;
      end
    end
endmodule

// File: tb/tb_jtcontra_layer_mix.sv
// tb_jtcontra_layer_mix: directed checks of priority, masking, palette access, blanking and reset
module tb_jtcontra_layer_mix;
  logic clk = 0, rst = 1, pxl_cen = 0, cpu_cen = 0, LHBL = 0, LVBL = 0;
  logic LHBL_dly, LVBL_dly, prio_rev = 0, pal_cs = 0, cpu_rnw = 1;
  logic [13:0] pxl_in = '0;
  logic [1:0]  gfx_en = '0;
  logic [8:0]  cpu_addr = '0;
  logic [7:0]  cpu_dout = '0, pal_dout;
  logic [4:0]  red, green, blue;
  logic [14:0] rgb;
  int tests = 0, fails = 0;
  assign rgb = {red, green, blue};

  jtcontra_layer_mix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen), .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .pxl_in(pxl_in), .gfx_en(gfx_en), .prio_rev(prio_rev),
    .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic pix();
    @(negedge clk) pxl_cen = 1;
    @(negedge clk) pxl_cen = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk) begin pal_cs = 1; cpu_rnw = 0; cpu_cen = 1; cpu_addr = a; cpu_dout = d; end
    @(negedge clk) begin pal_cs = 0; cpu_rnw = 1; cpu_cen = 0; end
  endtask

  task automatic rd(input logic [8:0] a);
    @(negedge clk) begin pal_cs = 1; cpu_rnw = 1; cpu_addr = a; end
    @(negedge clk) pal_cs = 0;
  endtask

  task automatic set_px(input logic [6:0] p0, input logic [6:0] p1, input logic [1:0] en, input logic rev);
    pxl_in = {p1, p0}; gfx_en = en; prio_rev = rev;
    pix(); pix();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({rgb, LHBL_dly, LVBL_dly, pal_dout} !== '0) begin
      fails++; $display("FAIL reset_state got rgb=%h dly=%b%b dout=%h want 0", rgb, LHBL_dly, LVBL_dly, pal_dout);
    end
    rst = 0; LHBL = 1; LVBL = 1;
  endtask

  task automatic test_cpu();
    wr(9'h00A, 8'h7C); wr(9'h00B, 8'h1F);
    wr(9'h106, 8'h03); wr(9'h107, 8'hE0);
    wr(9'h124, 8'h84); wr(9'h125, 8'h25);
    wr(9'h100, 8'h28); wr(9'h101, 8'h4A);
    wr(9'h060, 8'h55); wr(9'h061, 8'hAA);
    rd(9'h00A);
    tests++;
    if (pal_dout !== 8'h7C) begin fails++; $display("FAIL read_hi got %h want 7c", pal_dout); end
    rd(9'h00B);
    tests++;
    if (pal_dout !== 8'h1F) begin fails++; $display("FAIL read_lo got %h want 1f", pal_dout); end
    @(negedge clk) cpu_addr = 9'h00A;
    @(negedge clk);
    tests++;
    if (pal_dout !== 8'h1F) begin fails++; $display("FAIL read_hold got %h want 1f", pal_dout); end
    @(negedge clk) begin pal_cs = 1; cpu_rnw = 0; cpu_cen = 0; cpu_addr = 9'h00B; cpu_dout = 8'hFF; end
    @(negedge clk) begin pal_cs = 0; cpu_rnw = 1; end
    rd(9'h00B);
    tests++;
    if (pal_dout !== 8'h1F) begin fails++; $display("FAIL write_no_cen got %h want 1f", pal_dout); end
  endtask

  task automatic test_priority();
    set_px(7'h05, 7'h03, 2'b11, 0);
    tests++;
    if (rgb !== {5'd31, 5'd0, 5'd31}) begin fails++; $display("FAIL prio_normal got %h want %h", rgb, {5'd31, 5'd0, 5'd31}); end
    set_px(7'h05, 7'h03, 2'b11, 1);
    tests++;
    if (rgb !== {5'd0, 5'd31, 5'd0}) begin fails++; $display("FAIL prio_rev got %h want %h", rgb, {5'd0, 5'd31, 5'd0}); end
    set_px(7'h05, 7'h03, 2'b10, 0);
    tests++;
    if (rgb !== {5'd0, 5'd31, 5'd0}) begin fails++; $display("FAIL mask_layer0 got %h want %h", rgb, {5'd0, 5'd31, 5'd0}); end
  endtask

  task automatic test_backdrop();
    set_px(7'h00, 7'h12, 2'b11, 0);
    tests++;
    if (rgb !== {5'd5, 5'd1, 5'd1}) begin fails++; $display("FAIL layer1_wins got %h want %h", rgb, {5'd5, 5'd1, 5'd1}); end
    set_px(7'h00, 7'h12, 2'b01, 0);
    tests++;
    if (rgb !== {5'd5, 5'd1, 5'd1}) begin fails++; $display("FAIL backdrop_raw got %h want %h", rgb, {5'd5, 5'd1, 5'd1}); end
    set_px(7'h00, 7'h00, 2'b11, 0);
    tests++;
    if (rgb !== {5'd10, 5'd2, 5'd10}) begin fails++; $display("FAIL backdrop_zero got %h want %h", rgb, {5'd10, 5'd2, 5'd10}); end
    set_px(7'h30, 7'h00, 2'b11, 1);
    tests++;
    if (rgb !== {5'd10, 5'd13, 5'd21}) begin fails++; $display("FAIL backdrop_rev got %h want %h", rgb, {5'd10, 5'd13, 5'd21}); end
  endtask

  task automatic test_blank();
    set_px(7'h05, 7'h03, 2'b11, 0);
    LHBL = 0;
    pix();
    tests++;
    if (LHBL_dly !== 1'b1 || rgb !== {5'd31, 5'd0, 5'd31}) begin
      fails++; $display("FAIL blank_early got dly=%b rgb=%h want 1 %h", LHBL_dly, rgb, {5'd31, 5'd0, 5'd31});
    end
    LHBL = 1;
    pix();
    tests++;
    if (LHBL_dly !== 1'b0 || LVBL_dly !== 1'b1 || rgb !== 15'd0) begin
      fails++; $display("FAIL blank_active got dly=%b%b rgb=%h want 01 0", LHBL_dly, LVBL_dly, rgb);
    end
    pix();
    tests++;
    if (LHBL_dly !== 1'b1 || rgb !== {5'd31, 5'd0, 5'd31}) begin
      fails++; $display("FAIL blank_end got dly=%b rgb=%h want 1 %h", LHBL_dly, rgb, {5'd31, 5'd0, 5'd31});
    end
  endtask

  task automatic test_collision();
    @(negedge clk) pxl_cen = 1;
    @(negedge clk) begin pxl_cen = 0; pal_cs = 1; cpu_rnw = 0; cpu_cen = 1; cpu_addr = 9'h00A; cpu_dout = 8'h00; end
    @(negedge clk) begin pal_cs = 0; cpu_rnw = 1; cpu_cen = 0; end
    @(negedge clk);
    pix();
    tests++;
    if (rgb !== {5'd31, 5'd0, 5'd31}) begin fails++; $display("FAIL collide_old got %h want %h", rgb, {5'd31, 5'd0, 5'd31}); end
    pix();
    tests++;
    if (rgb !== {5'd31, 5'd0, 5'd0}) begin fails++; $display("FAIL collide_new got %h want %h", rgb, {5'd31, 5'd0, 5'd0}); end
    wr(9'h00A, 8'h7C);
    pix(); pix();
  endtask

  task automatic test_reset_midline();
    rd(9'h00A);
    @(negedge clk) #2 rst = 1;
    #1;
    tests++;
    if ({rgb, LHBL_dly, LVBL_dly, pal_dout} !== '0) begin
      fails++; $display("FAIL reset_mid got rgb=%h dly=%b%b dout=%h want 0", rgb, LHBL_dly, LVBL_dly, pal_dout);
    end
    @(negedge clk) rst = 0;
    rd(9'h00A);
    tests++;
    if (pal_dout !== 8'h7C) begin fails++; $display("FAIL reset_keep_hi got %h want 7c", pal_dout); end
    rd(9'h00B);
    tests++;
    if (pal_dout !== 8'h1F) begin fails++; $display("FAIL reset_keep_lo got %h want 1f", pal_dout); end
    pix();
    tests++;
    if (rgb !== 15'd0 || LHBL_dly !== 1'b0) begin fails++; $display("FAIL resume_early got rgb=%h dly=%b want 0 0", rgb, LHBL_dly); end
    pix();
    tests++;
    if (rgb !== {5'd31, 5'd0, 5'd31} || LHBL_dly !== 1'b1) begin
      fails++; $display("FAIL resume got rgb=%h dly=%b want %h 1", rgb, LHBL_dly, {5'd31, 5'd0, 5'd31});
    end
  endtask

  initial begin
    test_reset();
    test_cpu();
    test_priority();
    test_backdrop();
    test_blank();
    test_collision();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
